// File: rtl/inst_fetch.sv
// Instruction fetch stage: word-indexed PC, synchronous-read instruction memory,
// a small fetch buffer toward decode, branch redirects and halt-word detection.
module inst_fetch #(
  parameter int              ADDR_W     = 10,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter logic [31:0]     HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halt_seen
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_OCC_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [ADDR_W-1:0] pc_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] inflight_pc_r;
  logic [31:0]       fifo_data_r [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc_r   [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W:0]    occupancy_s;
  logic              issue_s;
  logic              resp_s;
  logic              push_s;
  logic              pop_s;
  logic              halt_hit_s;
  logic              full_s;

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (halt_hit_s) state_nx_s = ST_HALTED;
        else            state_nx_s = ST_RUN;
      end
      ST_HALTED: begin
        if (redirect_valid) state_nx_s = ST_RUN;
        else                state_nx_s = ST_HALTED;
      end
      default: state_nx_s = ST_RUN;
    endcase
  end

  // FSM outputs: issue under the credit rule, accept responses that are not squashed
  always_comb begin
    occupancy_s = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
    issue_s     = 1'b0;
    resp_s      = 1'b0;
    if (!RESET && (state_r == ST_RUN) && !redirect_valid) begin
      // Counting the in-flight read as occupied means a response always has a slot.
      issue_s = (occupancy_s < DEPTH_OCC_C);
      resp_s  = inflight_r;
    end else begin
      issue_s = 1'b0;
      resp_s  = 1'b0;
    end
  end

  assign halt_hit_s = resp_s && (imem_rdata == HALT_WORD);
  assign push_s     = resp_s;
  assign pop_s      = inst_valid && inst_ready && !redirect_valid;
  assign full_s     = (count_r == DEPTH_CNT_C);

  assign imem_en    = issue_s;
  assign imem_addr  = pc_r;
  assign inst_valid = (count_r != {CNT_W{1'b0}});
  assign inst_data  = fifo_data_r[rd_ptr_r];
  assign inst_pc    = fifo_pc_r[rd_ptr_r];
  assign halt_seen  = (state_r == ST_HALTED);

  // PC and in-flight read tracking
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      pc_r          <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= RESET_PC;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_pc_r <= pc_r;
      end
      if (redirect_valid) begin
        pc_r <= redirect_pc;
      end else if (issue_s) begin
        pc_r <= pc_r + ADDR_W'(1);
      end
    end
  end

  // Fetch buffer pointers and occupancy; a redirect flushes and overrides any pop
  always_ff @(posedge CLOCK_50) begin
    if (RESET || redirect_valid) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Fetch buffer storage
  always_ff @(posedge CLOCK_50) begin
    if (push_s) begin
      fifo_data_r[wr_ptr_r] <= imem_rdata;
      fifo_pc_r[wr_ptr_r]   <= inflight_pc_r;
    end
  end

  inst_fetch_chk u_chk (
    .clk  (CLOCK_50),
    .rst  (RESET),
    .push (push_s),
    .pop  (pop_s),
    .full (full_s)
  );

endmodule

// Protocol checks for the fetch buffer.
module inst_fetch_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic full
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios with literal expectations
// plus a randomized phase checked every cycle against a queue-based model.
module tb_inst_fetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
  localparam logic [31:0] FILL  = 32'b1100110_00001_000_00001_00001_0000000;

  typedef struct packed {
    logic [9:0]  pc;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic [9:0]  inst_pc;
  logic        redirect_valid = 1'b0;
  logic [9:0]  redirect_pc = 10'h0;
  logic        halt_seen;

  logic [31:0] mem [1024];
  int          errors = 0;
  int          checks = 0;

  // Model state: what the stage must hold after each edge
  ent_t        q[$];
  bit          model_ok = 1'b0;
  bit          inflight_m = 1'b0;
  logic [9:0]  inflight_addr_m = 10'h0;
  logic [9:0]  pc_m = 10'h0;
  bit          halted_m = 1'b0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .CLOCK_50       (clk),
    .RESET          (RESET),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_seen      (halt_seen)
  );

  // Synchronous-read instruction memory; garbage when not read
  always @(posedge clk) begin
    if (imem_en === 1'b1) imem_rdata <= mem[imem_addr];
    else                  imem_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle reference: compare outputs, then apply the coming edge to the model
  always @(negedge clk) begin
    bit         exp_issue;
    bit         exp_valid;
    bit         pop;
    bit         resp;
    logic [31:0] rdat;
    exp_issue = !RESET && !halted_m && !redirect_valid && ((q.size() + int'(inflight_m)) < DEPTH);
    exp_valid = (q.size() != 0);
    if (model_ok) begin
      chk("imem_en", imem_en, exp_issue);
      if (exp_issue) chk("imem_addr", imem_addr, pc_m);
      chk("inst_valid", inst_valid, exp_valid);
      if (exp_valid) begin
        chk("inst_pc", inst_pc, q[0].pc);
        chk("inst_data", inst_data, q[0].data);
      end
      chk("halt_seen", halt_seen, halted_m);
    end
    if (RESET) begin
      q.delete();
      inflight_m = 1'b0;
      pc_m       = 10'h000;
      halted_m   = 1'b0;
      model_ok   = 1'b1;
    end else begin
      resp = inflight_m && !redirect_valid && !halted_m;
      rdat = mem[inflight_addr_m];
      pop  = exp_valid && inst_ready && !redirect_valid;
      if (redirect_valid) begin
        q.delete();
        pc_m     = redirect_pc;
        halted_m = 1'b0;
      end else begin
        if (pop) void'(q.pop_front());
        if (resp) q.push_back('{pc: inflight_addr_m, data: rdat});
        if (resp && (rdat == HALT)) halted_m = 1'b1;
        if (exp_issue) pc_m = pc_m + 10'd1;
      end
      if (exp_issue) inflight_addr_m = imem_addr;
      inflight_m = exp_issue;
    end
  end

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    int  n;
    bit  found;
    for (int i = 0; i < 1024; i++) begin
      if (i < 32)       mem[i] = 32'h1000_0000 + i;
      else if (i < 64)  mem[i] = 32'h2000_0000 + i;
      else if (i >= 1022) mem[i] = 32'h3000_0000 + i;
      else              mem[i] = ($urandom_range(0, 11) == 0) ? HALT : $urandom;
    end
    for (int i = 4; i < 20; i++) mem[i] = FILL;
    mem[20] = HALT;

    // Reset release and first-fetch latency
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b0;
    sample();
    chk("t1_en_c0", imem_en, 1'b1);
    chk("t1_addr_c0", imem_addr, 10'h000);
    chk("t1_valid_c0", inst_valid, 1'b0);
    cyc_start(); sample();
    chk("t1_valid_c1", inst_valid, 1'b0);
    cyc_start(); sample();
    chk("t1_valid_c2", inst_valid, 1'b1);
    chk("t1_pc_c2", inst_pc, 10'h000);
    chk("t1_data_c2", inst_data, 32'h1000_0000);
    cyc_start(); sample();
    chk("t1_pc_c3", inst_pc, 10'h001);
    chk("t1_data_c3", inst_data, 32'h1000_0001);

    // Back-pressure fills the buffer, then drains in order
    cyc_start(); RESET = 1'b1; inst_ready = 1'b0; sample();
    cyc_start(); RESET = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (imem_en) n++;
      if (i == 9) begin
        chk("t2_en_stalled", imem_en, 1'b0);
        chk("t2_valid_stalled", inst_valid, 1'b1);
      end
      cyc_start();
    end
    chk("t2_issue_count", n, 4);
    inst_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sample();
      chk("t2_drain_valid", inst_valid, 1'b1);
      chk("t2_drain_pc", inst_pc, 10'(k));
      cyc_start();
    end

    // Redirect with 3 buffered and one read in flight
    RESET = 1'b1; inst_ready = 1'b0; sample();
    cyc_start(); RESET = 1'b0;
    repeat (4) begin sample(); cyc_start(); end
    redirect_valid = 1'b1; redirect_pc = 10'h020;
    sample();
    chk("t3_en_redirect", imem_en, 1'b0);
    chk("t3_valid_pre", inst_valid, 1'b1);
    cyc_start(); redirect_valid = 1'b0; sample();
    chk("t3_valid_n1", inst_valid, 1'b0);
    chk("t3_en_n1", imem_en, 1'b1);
    chk("t3_addr_n1", imem_addr, 10'h020);
    cyc_start(); sample();
    chk("t3_valid_n2", inst_valid, 1'b0);
    cyc_start(); sample();
    chk("t3_valid_n3", inst_valid, 1'b1);
    chk("t3_pc_n3", inst_pc, 10'h020);
    chk("t3_data_n3", inst_data, 32'h2000_0020);

    // Redirect beats a same-cycle pop; target near the top exercises PC wrap
    cyc_start(); inst_ready = 1'b1;
    repeat (3) begin sample(); cyc_start(); end
    redirect_valid = 1'b1; redirect_pc = 10'h3FE;
    sample();
    chk("t5_valid_at_redirect", inst_valid, 1'b1);
    cyc_start(); redirect_valid = 1'b0; sample();
    chk("t5_valid_n1", inst_valid, 1'b0);
    cyc_start(); sample();
    chk("t5_valid_n2", inst_valid, 1'b0);
    cyc_start(); sample();
    chk("t5_pc_n3", inst_pc, 10'h3FE);
    cyc_start(); sample();
    chk("t5_pc_n4", inst_pc, 10'h3FF);
    cyc_start(); sample();
    chk("t5_pc_wrap", inst_pc, 10'h000);
    chk("t5_data_wrap", inst_data, 32'h1000_0000);

    // Halt word at 20 is delivered, fetch then stays stopped
    cyc_start(); redirect_valid = 1'b1; redirect_pc = 10'h004; sample();
    cyc_start(); redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      sample();
      if (inst_valid && (inst_pc == 10'd20)) found = 1'b1;
      else cyc_start();
    end
    chk("t4_halt_reached", found, 1'b1);
    chk("t4_halt_data", inst_data, HALT);
    chk("t4_halt_seen", halt_seen, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc_start(); sample();
      chk("t4_en_halted", imem_en, 1'b0);
      chk("t4_no_pc21", inst_valid, 1'b0);
    end
    chk("t4_halt_sticky", halt_seen, 1'b1);

    // Reset clears a sticky halt
    cyc_start(); RESET = 1'b1; sample();
    cyc_start(); RESET = 1'b0; sample();
    chk("t6_halt_cleared", halt_seen, 1'b0);
    chk("t6_en_after_halt_reset", imem_en, 1'b1);

    // Reset with a busy buffer and a read in flight
    cyc_start(); redirect_valid = 1'b1; redirect_pc = 10'h020; inst_ready = 1'b0; sample();
    cyc_start(); redirect_valid = 1'b0;
    repeat (3) begin sample(); cyc_start(); end
    RESET = 1'b1; sample();
    chk("t6_valid_busy", inst_valid, 1'b1);
    cyc_start(); RESET = 1'b0; inst_ready = 1'b1; sample();
    chk("t6_valid_c0", inst_valid, 1'b0);
    chk("t6_halt_c0", halt_seen, 1'b0);
    chk("t6_addr_c0", imem_addr, 10'h000);
    cyc_start(); sample();
    chk("t6_valid_c1", inst_valid, 1'b0);
    cyc_start(); sample();
    chk("t6_pc_c2", inst_pc, 10'h000);
    chk("t6_data_c2", inst_data, 32'h1000_0000);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      cyc_start();
      RESET          = ($urandom_range(0, 299) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = 10'($urandom_range(0, 1023));
      inst_ready     = ($urandom_range(0, 3) != 0);
    end
    cyc_start();
    RESET = 1'b0; redirect_valid = 1'b0;
    sample();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
